// File: rtl/cache_pkg.sv
// Shared cache definitions: lookup/fill FSM states and default
// tag-store geometry used by tag_ctrl, Mtag and related blocks.
package cache_pkg;

   localparam int IDX_W_DEF = 2;
   localparam int TAG_W_DEF = 6;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CMP,
      FILL,
      WRITE,
      RESP
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports: clk, reset (sync, active-low), inc, cnt.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!reset)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/tag_ctrl.sv
// Direct-mapped cache lookup/fill controller; masters the Mtag write
// port, holds per-line valid bits and saturating hit/miss statistics.
// Ports: clk, reset (sync, active-low); CPU req_valid/req_addr/req_ready,
// resp_valid/resp_hit; Mtag tag_addr/tag_din/tag_we/tag_rdata;
// memory fill mem_req/mem_addr/mem_ack; stats hit_cnt/miss_cnt.
module tag_ctrl
   import cache_pkg::*;
#(
   parameter int IDX_W = cache_pkg::IDX_W_DEF,
   parameter int TAG_W = cache_pkg::TAG_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   input  logic [TAG_W+IDX_W-1:0] req_addr,
   output logic                   req_ready,
   output logic                   resp_valid,
   output logic                   resp_hit,
   output logic [IDX_W-1:0]       tag_addr,
   output logic [TAG_W-1:0]       tag_din,
   output logic                   tag_we,
   input  logic [TAG_W-1:0]       tag_rdata,
   output logic                   mem_req,
   output logic [TAG_W+IDX_W-1:0] mem_addr,
   input  logic                   mem_ack,
   output logic [CNT_W-1:0]       hit_cnt,
   output logic [CNT_W-1:0]       miss_cnt
);

   localparam int AW    = TAG_W + IDX_W;
   localparam int LINES = 1 << IDX_W;

   state_t             state;
   state_t             nxt;
   logic [AW-1:0]      addr_q;
   logic               hit_q;
   logic [LINES-1:0]   valid;
   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic               hit;

   assign idx = addr_q[IDX_W-1:0];
   assign tag = addr_q[AW-1:IDX_W];

   // An invalid line never hits, even if the stale tag matches.
   assign hit = valid[idx] && (tag_rdata == tag);

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (req_valid) nxt = READ;
         READ:    nxt = CMP;
         CMP:     nxt = hit ? RESP : FILL;
         FILL:    if (mem_ack) nxt = WRITE;
         WRITE:   nxt = RESP;
         RESP:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_req    = 1'b0;
      tag_we     = 1'b0;
      unique case (state)
         IDLE:    req_ready  = 1'b1;
         FILL:    mem_req    = 1'b1;
         WRITE:   tag_we     = 1'b1;
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q <= '0;
         hit_q  <= 1'b0;
         valid  <= '0;
      end else begin
         if ((state == IDLE) && req_valid)
            addr_q <= req_addr;
         if (state == CMP)
            hit_q <= hit;
         if (state == WRITE)
            valid[idx] <= 1'b1;
      end
   end

   // addr_q only moves in IDLE, so these stay stable READ..RESP.
   assign tag_addr = idx;
   assign tag_din  = tag;
   assign mem_addr = addr_q;
   assign resp_hit = resp_valid & hit_q;

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   ((state == CMP) && hit),
      .cnt   (hit_cnt)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   ((state == CMP) && !hit),
      .cnt   (miss_cnt)
   );

endmodule

// File: doc/tag_ctrl.md
# tag_ctrl

Direct-mapped cache lookup/fill controller that sits in front of the `Mtag` tag store and is the master of its write port. It accepts CPU lookup requests, reads the indexed tag, compares it, and on a miss runs a memory fill handshake and writes the new tag back through `Mtag`'s `address`/`din`/`Dwr` interface. Per-line valid bits and hit/miss statistics are held locally.

## Interface
- `IDX_W`, 2: index width; line count is 2^IDX_W and matches `Mtag` depth.
- `TAG_W`, 6: tag width; matches `Mtag` data width.
- `CNT_W`, 16: width of the hit and miss counters.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge, asserted when 0.
- `req_valid`  in  1  CPU lookup request.
- `req_addr`  in  TAG_W+IDX_W  request address; bits [IDX_W-1:0] are the index, the upper TAG_W bits are the tag.
- `req_ready`  out  1  high only in IDLE.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_hit`  out  1  1 = hit, 0 = miss that has completed its fill; valid only with `resp_valid`.
- `tag_addr`  out  IDX_W  drives `Mtag` `address`.
- `tag_din`  out  TAG_W  drives `Mtag` `din`.
- `tag_we`  out  1  drives `Mtag` `Dwr`.
- `tag_rdata`  in  TAG_W  from `Mtag` `Rout`.
- `mem_req`  out  1  fill request to next-level memory.
- `mem_addr`  out  TAG_W+IDX_W  fill address.
- `mem_ack`  in  1  fill complete.
- `hit_cnt`, `miss_cnt`  out  CNT_W  saturating statistics.

## Operation
- State machine: IDLE, READ, CMP, FILL, WRITE, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, latch `req_addr` into `addr_q` and go to READ.
- `tag_addr` is always driven from `addr_q` index bits and stays stable from READ through RESP.
- READ: one wait cycle so that `tag_rdata` is settled whether `Mtag` reads combinationally or through a register. Go to CMP.
- CMP: hit = `valid[idx]` and (`tag_rdata` == tag). On a hit, increment `hit_cnt` and go to RESP with hit=1. On a miss, increment `miss_cnt` and go to FILL.
- FILL: `mem_req`=1 and `mem_addr`=`addr_q`, both held stable until `mem_ack`=1 is sampled, then go to WRITE.
- WRITE: exactly one cycle with `tag_we`=1 and `tag_din`=tag; set `valid[idx]`. Go to RESP with hit=0.
- RESP: `resp_valid`=1 for exactly one cycle. Return to IDLE.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Reset values (and values while reset=0): state IDLE, `valid` all 0, `req_ready` 1, and `resp_valid`, `resp_hit`, `tag_we`, `mem_req`, `tag_addr`, `tag_din`, `mem_addr`, `hit_cnt`, `miss_cnt` all 0.
- All outputs are registered or decoded from the registered state; there is no combinational path from input to output.
- Hit latency: acceptance edge E0 → `resp_valid` high in the 3rd cycle after E0.
- Miss latency: 3 + k + 1 cycles, where k ≥ 1 is the number of FILL cycles. With `mem_ack` high in the first FILL cycle, `resp_valid` is high in the 5th cycle.
- `req_valid` outside IDLE is ignored; no request is buffered.
- `mem_ack` outside FILL is ignored.
- A line with valid=0 always misses, even when `tag_rdata` equals the tag (e.g. tag 0 after reset).
- Back-to-back requests to the same index: the WRITE completes before RESP, so the next request sees the new tag.
- Reset asserted mid-operation (including during FILL): on the next edge, `mem_req` and `tag_we` drop, state returns to IDLE, no response is issued, and valid bits and counters are cleared.

## Structure
- Shared package `cache_pkg`: the state enum (IDLE..RESP) and default IDX_W/TAG_W constants. `Mtag` and other cache blocks use the same package.
- Single flat module; the two saturating counters may use one small `sat_counter` sub-module instantiated twice.
- `Mtag` is not instantiated inside this block. The bench wires `tag_ctrl` to `Mtag`.

## Test plan
- Reset, then request 0x25 (tag 9, idx 1): miss. Check `mem_addr`=0x25, then one cycle of `tag_we` with `tag_addr`=1 and `tag_din`=9, then `resp_valid` with `resp_hit`=0 and `miss_cnt`=1.
- Repeat 0x25: `resp_hit`=1 exactly 3 cycles after acceptance, `mem_req` never asserted, `hit_cnt`=1.
- Request 0x05 (tag 1, idx 1): miss and replace. A following request for 0x25 misses again.
- After reset, request 0x00 while `Mtag` returns 0: miss, because of the valid bit.
- Delay `mem_ack` by 4 cycles: `mem_req` and `mem_addr` held stable for the whole wait, `req_valid` pulses ignored, response in the 8th cycle.
- Drive reset=0 during FILL: `mem_req` falls next edge, no `resp_valid`, counters read 0, and the next request to the same address misses.
